// File: rtl/arb_mux_pkg.sv
// Shared defaults and mode encodings for the arbitrating output mux.
// Imported by the interface, the priority picker and the top.
package arb_mux_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/arb_mux_if.sv
// Channel-side and output-side handshake bundle for arb_mux.
// The slave modport is the mux; the master modport is whoever feeds and drains it.
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int SELW    = $clog2(CHANNELS)
);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic                      out_ready;
    logic [SELW-1:0]           out_chan;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/arb_mux_rr_pick.sv
// Rotating-priority picker: first asserted request at or above ptr, wrapping.
// CHANNELS is a power of two, so the index sum wraps for free.
module rr_pick #(
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grantIdx,
    output logic                any
);

    logic [SELW-1:0] cand;

    always_comb begin
        cand     = '0;
        grantIdx = '0;
        any      = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = ptr + SELW'(i);
            if (!any && req[cand]) begin
                any      = 1'b1;
                grantIdx = cand;
            end
        end
        grant = any ? (CHANNELS'(1) << grantIdx) : '0;
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 registered mux with fixed-select or round-robin arbitration.
// One output slot; a new word loads whenever the slot is empty or draining.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    arb_mux_if.slave        bus
);

    logic [WIDTH-1:0]    chData [CHANNELS];
    logic [CHANNELS-1:0] rrGrant;
    logic [SELW-1:0]     rrIdx;
    logic                rrAny;
    logic [CHANNELS-1:0] fixGrant;
    logic [CHANNELS-1:0] grantVec;
    logic [SELW-1:0]     gIdx;
    logic                loadSlot;
    logic                xfer;

    logic                outValidQ;
    logic [WIDTH-1:0]    outDataQ;
    logic [SELW-1:0]     outChanQ;
    logic [SELW-1:0]     ptr;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign chData[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

    rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req      (bus.in_valid),
        .ptr      (ptr),
        .grant    (rrGrant),
        .grantIdx (rrIdx),
        .any      (rrAny)
    );

    assign loadSlot = !outValidQ || bus.out_ready;
    assign fixGrant = bus.in_valid[sel] ? (CHANNELS'(1) << sel) : '0;

    always_comb begin
        grantVec = fixGrant;
        gIdx     = sel;
        if (mode == MODE_RR) begin
            grantVec = rrAny ? rrGrant : '0;
            gIdx     = rrIdx;
        end
    end

    // Reset gates ready combinationally so nothing is accepted while held.
    assign bus.in_ready = (rst_n && loadSlot) ? grantVec : '0;
    assign xfer         = |bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outChanQ  <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            outValidQ <= 1'b1;
            outDataQ  <= chData[gIdx];
            outChanQ  <= gIdx;
            if (mode == MODE_RR)
                ptr <= gIdx + SELW'(1);
        end else if (bus.out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    assign bus.out_valid = outValidQ;
    assign bus.out_data  = outDataQ;
    assign bus.out_chan  = outChanQ;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: fixed select, round-robin order, backpressure,
// pointer wrap, reset mid-operation, idle drain and mode change under hold.
module tb_arb_mux;
    import arb_mux_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] d [4];
    int         nCmp;
    int         nBad;

    arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    arb_mux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setData();
        bus.in_data = {d[3], d[2], d[1], d[0]};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = MODE_FIXED; sel = 2'd0;
        d = '{8'h11, 8'h22, 8'hA5, 8'h44};
        setData();
        bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0000) begin nBad++; $display("FAIL reset_ready got=%b want=0000", bus.in_ready); end
        tick(); tick();
        nCmp++; if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        nCmp++; if (bus.out_data !== 8'h00) begin nBad++; $display("FAIL reset_data got=%h want=00", bus.out_data); end
        nCmp++; if (bus.out_chan !== 2'd0) begin nBad++; $display("FAIL reset_chan got=%0d want=0", bus.out_chan); end
        nCmp++; if (dut.ptr !== 2'd0) begin nBad++; $display("FAIL reset_ptr got=%0d want=0", dut.ptr); end
        bus.in_valid = 4'b0000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        mode = MODE_FIXED; sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0100) begin nBad++; $display("FAIL fixed_ready got=%b want=0100", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_valid !== 1'b1) begin nBad++; $display("FAIL fixed_valid got=%b want=1", bus.out_valid); end
        nCmp++; if (bus.out_data !== 8'hA5) begin nBad++; $display("FAIL fixed_data got=%h want=a5", bus.out_data); end
        nCmp++; if (bus.out_chan !== 2'd2) begin nBad++; $display("FAIL fixed_chan got=%0d want=2", bus.out_chan); end
        nCmp++; if (dut.ptr !== 2'd0) begin nBad++; $display("FAIL fixed_ptr got=%0d want=0", dut.ptr); end
        // Selected channel not valid: nothing granted, slot drains.
        sel = 2'd0; bus.in_valid = 4'b1110;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0000) begin nBad++; $display("FAIL fixed_nosel_ready got=%b want=0000", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL fixed_drain_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_rr();
        logic [3:0] expRdy;
        mode = MODE_RR; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expRdy = 4'b0001 << (i % 4);
            #1;
            nCmp++; if (bus.in_ready !== expRdy) begin nBad++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, bus.in_ready, expRdy); end
            tick();
            nCmp++; if (bus.out_chan !== 2'(i % 4)) begin nBad++; $display("FAIL rr_chan[%0d] got=%0d want=%0d", i, bus.out_chan, i % 4); end
            nCmp++; if (bus.out_data !== d[i % 4]) begin nBad++; $display("FAIL rr_data[%0d] got=%h want=%h", i, bus.out_data, d[i % 4]); end
        end
        nCmp++; if (dut.ptr !== 2'd0) begin nBad++; $display("FAIL rr_ptr_end got=%0d want=0", dut.ptr); end
    endtask

    task automatic test_backpressure();
        mode = MODE_FIXED; sel = 2'd1; d[1] = 8'h3C; setData();
        bus.in_valid = 4'b0010; bus.out_ready = 1'b1;
        tick();
        nCmp++; if (bus.out_data !== 8'h3C) begin nBad++; $display("FAIL bp_load got=%h want=3c", bus.out_data); end
        bus.out_ready = 1'b0; d[1] = 8'h5A; setData();
        for (int i = 0; i < 3; i++) begin
            #1;
            nCmp++; if (bus.in_ready !== 4'b0000) begin nBad++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, bus.in_ready); end
            tick();
            nCmp++; if (bus.out_data !== 8'h3C || bus.out_valid !== 1'b1 || bus.out_chan !== 2'd1) begin
                nBad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/3c/1", i, bus.out_valid, bus.out_data, bus.out_chan);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0010) begin nBad++; $display("FAIL bp_release_ready got=%b want=0010", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_data !== 8'h5A) begin nBad++; $display("FAIL bp_next_data got=%h want=5a", bus.out_data); end
    endtask

    task automatic test_wrap();
        mode = MODE_RR; bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
        tick();
        nCmp++; if (bus.out_chan !== 2'd2) begin nBad++; $display("FAIL wrap_setup_chan got=%0d want=2", bus.out_chan); end
        nCmp++; if (dut.ptr !== 2'd3) begin nBad++; $display("FAIL wrap_setup_ptr got=%0d want=3", dut.ptr); end
        bus.in_valid = 4'b0010;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0010) begin nBad++; $display("FAIL wrap_ready got=%b want=0010", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_chan !== 2'd1) begin nBad++; $display("FAIL wrap_chan got=%0d want=1", bus.out_chan); end
        nCmp++; if (bus.out_data !== 8'h5A) begin nBad++; $display("FAIL wrap_data got=%h want=5a", bus.out_data); end
        nCmp++; if (dut.ptr !== 2'd2) begin nBad++; $display("FAIL wrap_ptr got=%0d want=2", dut.ptr); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0; bus.in_valid = 4'b1111; rst_n = 1'b0;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0000) begin nBad++; $display("FAIL rstmid_ready got=%b want=0000", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_chan !== 2'd0) begin
            nBad++; $display("FAIL rstmid_out got=%b/%h/%0d want=0/00/0", bus.out_valid, bus.out_data, bus.out_chan);
        end
        nCmp++; if (dut.ptr !== 2'd0) begin nBad++; $display("FAIL rstmid_ptr got=%0d want=0", dut.ptr); end
        rst_n = 1'b1;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0001) begin nBad++; $display("FAIL rstmid_resume_ready got=%b want=0001", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_data !== 8'h11 || bus.out_chan !== 2'd0) begin nBad++; $display("FAIL rstmid_resume got=%h/%0d want=11/0", bus.out_data, bus.out_chan); end
    endtask

    task automatic test_idle();
        bus.in_valid = 4'b0000; bus.out_ready = 1'b1;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0000) begin nBad++; $display("FAIL idle_ready0 got=%b want=0000", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL idle_valid0 got=%b want=0", bus.out_valid); end
        nCmp++; if (bus.in_ready !== 4'b0000) begin nBad++; $display("FAIL idle_ready1 got=%b want=0000", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL idle_valid1 got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_mode_switch();
        mode = MODE_RR; bus.in_valid = 4'b1000; bus.out_ready = 1'b0;
        tick();
        nCmp++; if (bus.out_chan !== 2'd3 || bus.out_data !== 8'h44) begin nBad++; $display("FAIL msw_load got=%0d/%h want=3/44", bus.out_chan, bus.out_data); end
        mode = MODE_FIXED; sel = 2'd0; bus.in_valid = 4'b0001;
        tick(); tick();
        nCmp++; if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd3 || bus.out_data !== 8'h44) begin
            nBad++; $display("FAIL msw_hold got=%b/%0d/%h want=1/3/44", bus.out_valid, bus.out_chan, bus.out_data);
        end
        bus.out_ready = 1'b1;
        #1;
        nCmp++; if (bus.in_ready !== 4'b0001) begin nBad++; $display("FAIL msw_ready got=%b want=0001", bus.in_ready); end
        tick();
        nCmp++; if (bus.out_chan !== 2'd0 || dut.ptr !== 2'd0) begin nBad++; $display("FAIL msw_fixed got=%0d ptr=%0d want=0 ptr=0", bus.out_chan, dut.ptr); end
    endtask

    initial begin
        nCmp = 0;
        nBad = 0;
        test_reset();
        test_fixed();
        test_rr();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_idle();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..32).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (power of two, 2..16).
REQ-003 SHALL derive localparam SELW = clog2(CHANNELS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 SHALL have port sel  input  SELW  channel index used when mode=0.
REQ-008 SHALL have port in_valid  input  CHANNELS  per-channel data valid.
REQ-009 SHALL have port in_data  input  CHANNELS*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port in_ready  output  CHANNELS  per-channel accept strobe.
REQ-011 SHALL have port out_valid  output  1  output register holds a word.
REQ-012 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have port out_chan  output  SELW  index of channel that supplied out_data.

Function
REQ-015 SHALL define load = !out_valid || out_ready (output slot free this cycle).
REQ-016 SHALL, with mode=0, grant channel sel iff in_valid[sel]; other channels never granted.
REQ-017 SHALL, with mode=1, grant the first channel with in_valid set, searching upward from ptr and wrapping CHANNELS-1 -> 0.
REQ-018 SHALL assert in_ready[k] only for the granted channel k and only when load=1; at most one bit set (one-hot or zero).
REQ-019 SHALL, on a transfer (in_valid[k] && in_ready[k]), register in_data[k] into out_data, k into out_chan, and set out_valid on the next edge: latency 1 cycle.
REQ-020 SHALL clear out_valid when out_ready=1 and no transfer occurs in that cycle.
REQ-021 SHALL hold out_data, out_chan, out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one word per cycle when out_ready stays 1 (simultaneous drain and load).
REQ-023 SHALL, in mode=1, update ptr to (k+1) mod CHANNELS after a transfer from k; ptr unchanged without transfer.
REQ-024 SHALL leave ptr unchanged in mode=0; mode changes take effect at the next grant decision, never disturbing a held output word.
REQ-025 SHALL pass data unchanged (no XOR/masking); out_data is 0 after reset until first transfer.
REQ-026 SHALL tolerate in_valid dropping without handshake; no word is lost or duplicated.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, set out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 SHALL force in_ready=0 while rst_n=0, discarding any in-flight output word (reset mid-transfer drops it).
REQ-029 SHALL resume grants on the first cycle after rst_n returns to 1.

Structure
REQ-030 SHALL place default WIDTH/CHANNELS constants and mode encodings (MODE_FIXED=0, MODE_RR=1) in shared package arb_mux_pkg.
REQ-031 SHALL implement the rotating priority search in one sub-module rr_pick (inputs req, ptr; outputs grant one-hot, grant index, any).
REQ-032 SHALL keep all registers in a single clocked process in arb_mux; grant logic purely combinational.

Verification
REQ-033 SHALL check fixed mode: mode=0, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_chan=2.
REQ-034 SHALL check round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
REQ-035 SHALL check backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 3 cycles -> in_ready=0, out_data=8'h3C stable; out_ready=1 -> next word loaded same cycle.
REQ-036 SHALL check wrap/skip: mode=1, ptr=3, in_valid=4'b0010 -> grant channel 1, ptr becomes 2.
REQ-037 SHALL check reset mid-operation: out_valid=1, rst_n=0 one edge -> out_valid=0, out_data=0, ptr=0, in_ready=0.
REQ-038 SHALL check idle: in_valid=0, out_ready=1 -> out_valid clears after one cycle, no in_ready pulses.
